// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC CPU: fetch (T0-T2) then per-opcode execute,
// decoding IR into the one-hot strobes, bus selects and ALU code that DataPath consumes.
module control_sequencer #(
  parameter logic [4:0] RESET_PC_INC = 5'b11111
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        Pout,
  output logic        MARen,
  output logic        ZLOen,
  output logic        ZLOout,
  output logic        Pen,
  output logic        Read,
  output logic        Write,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Yen,
  output logic        Cout,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_reg, is_addi, is_ld, is_st, is_halt;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_reg  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi = (opcode == OP_ADDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_halt = (opcode == OP_HALT);

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_code = 5'b00100;
      OP_AND:  alu_code = 5'b00101;
      OP_OR:   alu_code = 5'b00110;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'd1 << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) state <= S_RST;
    else      state <= state_nxt;
  end

  // T1 is split into a first cycle and a wait state so Pen/ZLOout pulse only once
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:       state_nxt = S_T0;
      S_T0:        state_nxt = (stop || is_halt) ? S_HALT : S_T1;
      S_T1, S_T1W: state_nxt = mem_ready ? S_T2 : S_T1W;
      S_T2:        state_nxt = S_T3;
      S_T3: begin
        if (is_reg || is_addi || is_ld || is_st) state_nxt = S_T4;
        else if (is_halt)                        state_nxt = S_HALT;
        else                                     state_nxt = S_T0;
      end
      S_T4:        state_nxt = S_T5;
      S_T5:        state_nxt = (is_ld || is_st) ? S_T6 : S_T0;
      S_T6:        if (is_st || mem_ready) state_nxt = S_T7;
      S_T7:        if (is_ld || mem_ready) state_nxt = S_T0;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_RST;
    endcase
  end

  always_comb begin
    Pout = 1'b0; MARen = 1'b0; ZLOen = 1'b0; ZLOout = 1'b0; Pen = 1'b0;
    Read = 1'b0; Write = 1'b0; MDRen = 1'b0; MDROut = 1'b0; IRen = 1'b0;
    Yen = 1'b0; Cout = 1'b0; Rin = 16'd0; Rout = 16'd0; alu_control = 5'd0;
    illegal_op = 1'b0;
    run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        Pout = 1'b1; MARen = 1'b1; ZLOen = 1'b1; alu_control = RESET_PC_INC;
      end
      S_T1: begin
        ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
      end
      S_T1W: begin
        Read = 1'b1; MDRen = 1'b1;
      end
      S_T2: begin
        MDROut = 1'b1; IRen = 1'b1;
      end
      S_T3: begin
        if (is_reg || is_addi || is_ld || is_st) begin
          Rout = onehot(rb); Yen = 1'b1;
        end else if (!is_halt) begin
          illegal_op = 1'b1;
        end
      end
      S_T4: begin
        ZLOen = 1'b1;
        alu_control = alu_code(opcode);
        if (is_reg) Rout = onehot(rc);
        else        Cout = 1'b1;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (is_ld || is_st) MARen = 1'b1;
        else                Rin = onehot(ra);
      end
      S_T6: begin
        MDRen = 1'b1;
        if (is_st) Rout = onehot(ra);
        else       Read = 1'b1;
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDROut = 1'b1; Rin = onehot(ra);
        end
      end
      default: ;
    endcase
  end

endmodule
